id_issue: RTL and testbench

Parametrised decode/issue stage for the five-stage MIPS core, sitting between the IF/ID register and EX. It decodes the logic/shift subset, reads the register file, and forwards results from any number of later stages. It detects load-use hazards and inserts a one-cycle bubble. Results are held in an internal ID/EX register behind a valid/ready handshake, so EX back-pressure and branch flushes are handled locally.

---
 rtl/id_issue_pkg.sv | 39 +++
 rtl/id_fwd_mux.sv | 31 +++
 rtl/id_issue.sv | 195 +++++++++++++++++++
 tb/tb_id_issue.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_issue_pkg.sv
// Shared MIPS decode constants for the decode/issue stage: opcodes, funct codes,
// ALU operation/select codes and the architectural zero register.
package id_issue_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;

    typedef enum logic [7:0] {
        ALUOP_NOP = 8'b00000000,
        ALUOP_SRL = 8'b00000010,
        ALUOP_SRA = 8'b00000011,
        ALUOP_AND = 8'b00100100,
        ALUOP_OR  = 8'b00100101,
        ALUOP_XOR = 8'b00100110,
        ALUOP_NOR = 8'b00100111,
        ALUOP_SLL = 8'b01111100
    } alu_op_e;

    typedef enum logic [2:0] {
        ALUSEL_NOP   = 3'b000,
        ALUSEL_LOGIC = 3'b001,
        ALUSEL_SHIFT = 3'b010
    } alu_sel_e;

    localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;
    localparam logic [31:0] ZERO_WORD    = 32'h00000000;

endpackage

// File: rtl/id_fwd_mux.sv
// Priority operand selector: register 0 reads as zero, otherwise the youngest
// writing stage with a matching destination wins over the register file.
module id_fwd_mux
    import id_issue_pkg::*;
#(
    parameter int FWD_N  = 2,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0]       addr,
    input  logic [DATA_W-1:0]       rf_data,
    input  logic [FWD_N-1:0]        fwd_we,
    input  logic [FWD_N*REG_AW-1:0] fwd_addr,
    input  logic [FWD_N*DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0]       data
);

    // Scan oldest to youngest so the lowest matching index is the last to write.
    always_comb begin
        data = rf_data;
        for (int i = FWD_N - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_addr[i*REG_AW +: REG_AW] == addr)) begin
                data = fwd_data[i*DATA_W +: DATA_W];
            end
        end
        if (addr == REG_AW'(NOP_REG_ADDR)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/id_issue.sv
// Decode/issue stage: decodes the logic/shift subset, forwards operands, stalls
// one cycle on load-use and holds the result in an ID/EX valid/ready register.
module id_issue
    import id_issue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int FWD_N  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             pc,
    input  logic [31:0]             inst,
    output logic [REG_AW-1:0]       rs_addr,
    output logic [REG_AW-1:0]       rt_addr,
    input  logic [DATA_W-1:0]       rs_data,
    input  logic [DATA_W-1:0]       rt_data,
    input  logic [FWD_N-1:0]        fwd_we,
    input  logic [FWD_N*REG_AW-1:0] fwd_addr,
    input  logic [FWD_N*DATA_W-1:0] fwd_data,
    input  logic                    ex_load,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc,
    output logic [7:0]              aluop,
    output logic [2:0]              alusel,
    output logic [DATA_W-1:0]       reg1,
    output logic [DATA_W-1:0]       reg2,
    output logic [REG_AW-1:0]       w_addr,
    output logic                    we,
    output logic                    illegal
);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [4:0]        shamt;
    logic [REG_AW-1:0] rd_addr;

    assign opcode  = inst[31:26];
    assign funct   = inst[5:0];
    assign imm     = inst[15:0];
    assign shamt   = inst[10:6];
    assign rs_addr = REG_AW'(inst[25:21]);
    assign rt_addr = REG_AW'(inst[20:16]);
    assign rd_addr = REG_AW'(inst[15:11]);

    alu_op_e           dec_aluop;
    alu_sel_e          dec_alusel;
    logic              dec_we;
    logic              dec_illegal;
    logic [REG_AW-1:0] dec_waddr;
    logic              rs_rd;
    logic              rt_rd;
    logic [DATA_W-1:0] imm1;
    logic [DATA_W-1:0] imm2;

    // Instruction decode; imm1/imm2 supply the operand whenever a port is not read.
    always_comb begin
        dec_aluop   = ALUOP_NOP;
        dec_alusel  = ALUSEL_NOP;
        dec_we      = 1'b0;
        dec_illegal = 1'b0;
        dec_waddr   = REG_AW'(NOP_REG_ADDR);
        rs_rd       = 1'b0;
        rt_rd       = 1'b0;
        imm1        = '0;
        imm2        = '0;
        case (opcode)
            OP_ORI, OP_ANDI, OP_XORI: begin
                dec_alusel = ALUSEL_LOGIC;
                dec_we     = 1'b1;
                dec_waddr  = rt_addr;
                rs_rd      = 1'b1;
                imm2       = DATA_W'(imm);
                case (opcode)
                    OP_ANDI: dec_aluop = ALUOP_AND;
                    OP_XORI: dec_aluop = ALUOP_XOR;
                    default: dec_aluop = ALUOP_OR;
                endcase
            end
            OP_LUI: begin
                dec_aluop  = ALUOP_OR;
                dec_alusel = ALUSEL_LOGIC;
                dec_we     = 1'b1;
                dec_waddr  = rt_addr;
                imm2       = DATA_W'({imm, 16'h0000});
            end
            OP_SPECIAL: begin
                if (inst != ZERO_WORD) begin
                    case (funct)
                        FN_OR, FN_AND, FN_XOR, FN_NOR: begin
                            dec_alusel = ALUSEL_LOGIC;
                            dec_we     = 1'b1;
                            dec_waddr  = rd_addr;
                            rs_rd      = 1'b1;
                            rt_rd      = 1'b1;
                            case (funct)
                                FN_AND:  dec_aluop = ALUOP_AND;
                                FN_XOR:  dec_aluop = ALUOP_XOR;
                                FN_NOR:  dec_aluop = ALUOP_NOR;
                                default: dec_aluop = ALUOP_OR;
                            endcase
                        end
                        FN_SLL, FN_SRL, FN_SRA: begin
                            dec_alusel = ALUSEL_SHIFT;
                            dec_we     = 1'b1;
                            dec_waddr  = rd_addr;
                            rt_rd      = 1'b1;
                            imm1       = DATA_W'(shamt);
                            case (funct)
                                FN_SRL:  dec_aluop = ALUOP_SRL;
                                FN_SRA:  dec_aluop = ALUOP_SRA;
                                default: dec_aluop = ALUOP_SLL;
                            endcase
                        end
                        default: dec_illegal = 1'b1;
                    endcase
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    id_fwd_mux #(.FWD_N(FWD_N), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .addr     (rs_addr),
        .rf_data  (rs_data),
        .fwd_we   (fwd_we),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data),
        .data     (rs_val)
    );

    id_fwd_mux #(.FWD_N(FWD_N), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .addr     (rt_addr),
        .rf_data  (rt_data),
        .fwd_we   (fwd_we),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data),
        .data     (rt_val)
    );

    logic [DATA_W-1:0] dec_reg1;
    logic [DATA_W-1:0] dec_reg2;

    assign dec_reg1 = rs_rd ? rs_val : imm1;
    assign dec_reg2 = rt_rd ? rt_val : imm2;

    // A load in EX cannot forward yet; its result is only usable from stage 1.
    logic [REG_AW-1:0] ex_dst;
    logic              hazard;
    logic              accept;

    assign ex_dst   = fwd_addr[REG_AW-1:0];
    assign hazard   = in_valid & ex_load & fwd_we[0] & (ex_dst != '0)
                    & ((rs_rd & (ex_dst == rs_addr)) | (rt_rd & (ex_dst == rt_addr)));
    assign in_ready = ~hazard & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    // ID/EX register; flush only drops valid, the payload is don't-care until reloaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            aluop     <= ALUOP_NOP;
            alusel    <= ALUSEL_NOP;
            reg1      <= '0;
            reg2      <= '0;
            w_addr    <= '0;
            we        <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_pc    <= pc;
            aluop     <= dec_aluop;
            alusel    <= dec_alusel;
            reg1      <= dec_reg1;
            reg2      <= dec_reg2;
            w_addr    <= dec_waddr;
            we        <= dec_we;
            illegal   <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_issue.sv
// Self-checking bench for id_issue: directed scenarios followed by random traffic,
// all compared against a behavioural model of the decode/issue rules.
module tb_id_issue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic        ex_load;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  w_addr;
    logic        we;
    logic        illegal;

    int tests_run  = 0;
    int fail_count = 0;

    id_issue #(.DATA_W(32), .REG_AW(5), .FWD_N(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc        (pc),
        .inst      (inst),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .fwd_we    (fwd_we),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .ex_load   (ex_load),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .aluop     (aluop),
        .alusel    (alusel),
        .reg1      (reg1),
        .reg2      (reg2),
        .w_addr    (w_addr),
        .we        (we),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic        we;
        logic [4:0]  waddr;
        logic        illegal;
        logic        rd_rs;
        logic        rd_rt;
        logic [31:0] r1;
        logic [31:0] r2;
    } dec_t;

    // Model of the architectural ID/EX register contents.
    logic        m_valid;
    logic [31:0] m_pc;
    dec_t        m_dec;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
        for (int i = 0; i < 2; i++) begin
            if (fwd_we[i] && fwd_addr[i*5 +: 5] == a) return fwd_data[i*32 +: 32];
        end
        return rf;
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        dec_t d;
        d = '0;
        case (w[31:26])
            6'h0d, 6'h0c, 6'h0e: begin
                d.aluop  = (w[31:26] == 6'h0c) ? 8'h24 : (w[31:26] == 6'h0e) ? 8'h26 : 8'h25;
                d.alusel = 3'b001; d.we = 1'b1; d.waddr = w[20:16]; d.rd_rs = 1'b1;
                d.r1 = a; d.r2 = {16'h0000, w[15:0]};
            end
            6'h0f: begin
                d.aluop = 8'h25; d.alusel = 3'b001; d.we = 1'b1; d.waddr = w[20:16];
                d.r2 = {w[15:0], 16'h0000};
            end
            6'h00: begin
                if (w != 32'd0) begin
                    case (w[5:0])
                        6'h25, 6'h24, 6'h26, 6'h27: begin
                            d.aluop  = (w[5:0] == 6'h25) ? 8'h25 : (w[5:0] == 6'h24) ? 8'h24 :
                                       (w[5:0] == 6'h26) ? 8'h26 : 8'h27;
                            d.alusel = 3'b001; d.we = 1'b1; d.waddr = w[15:11];
                            d.rd_rs = 1'b1; d.rd_rt = 1'b1; d.r1 = a; d.r2 = b;
                        end
                        6'h00, 6'h02, 6'h03: begin
                            d.aluop  = (w[5:0] == 6'h00) ? 8'h7c : (w[5:0] == 6'h02) ? 8'h02 : 8'h03;
                            d.alusel = 3'b010; d.we = 1'b1; d.waddr = w[15:11];
                            d.rd_rt = 1'b1; d.r1 = {27'd0, w[10:6]}; d.r2 = b;
                        end
                        default: d.illegal = 1'b1;
                    endcase
                end
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0] rs, rt, rd, sh;
        logic [5:0] fn_list [7];
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        sh = 5'($urandom_range(0, 31));
        fn_list = '{6'h25, 6'h24, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03};
        case ($urandom_range(0, 9))
            0: return {6'h0d, rs, rt, 16'($urandom)};
            1: return {6'h0c, rs, rt, 16'($urandom)};
            2: return {6'h0e, rs, rt, 16'($urandom)};
            3: return {6'h0f, 5'd0, rt, 16'($urandom)};
            4, 5, 6: return {6'h00, rs, rt, rd, sh, fn_list[$urandom_range(0, 6)]};
            7: return 32'd0;
            8: return {6'h3f, 26'($urandom)};
            default: return {6'h00, rs, rt, rd, 5'd0, 6'h08};
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc    = '0;
        m_dec   = '0;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; pc = '0; inst = '0;
        rs_data = '0; rt_data = '0; fwd_we = '0; fwd_addr = '0; fwd_data = '0;
        ex_load = 1'b0; out_ready = 1'b1;
    endtask

    // One clock cycle: check combinational outputs, step the model, check the register.
    task automatic apply_stimulus();
        dec_t        d;
        logic        hz, rdy, acc;
        #1;
        d   = ref_decode(inst, ref_operand(inst[25:21], rs_data), ref_operand(inst[20:16], rt_data));
        hz  = in_valid && ex_load && fwd_we[0] && (fwd_addr[4:0] != 5'd0) &&
              ((d.rd_rs && fwd_addr[4:0] == inst[25:21]) || (d.rd_rt && fwd_addr[4:0] == inst[20:16]));
        rdy = !hz && (!m_valid || out_ready);
        acc = in_valid && rdy;
        check_output("in_ready", 64'(in_ready), 64'(rdy));
        check_output("rs_addr", 64'(rs_addr), 64'(inst[25:21]));
        check_output("rt_addr", 64'(rt_addr), 64'(inst[20:16]));
        @(posedge clk);
        if (rst) model_reset();
        else if (flush) m_valid = 1'b0;
        else if (acc) begin m_valid = 1'b1; m_pc = pc; m_dec = d; end
        else if (out_ready) m_valid = 1'b0;
        #1;
        check_output("out_valid", 64'(out_valid), 64'(m_valid));
        check_output("out_pc", 64'(out_pc), 64'(m_pc));
        check_output("aluop", 64'(aluop), 64'(m_dec.aluop));
        check_output("alusel", 64'(alusel), 64'(m_dec.alusel));
        check_output("reg1", 64'(reg1), 64'(m_dec.r1));
        check_output("reg2", 64'(reg2), 64'(m_dec.r2));
        check_output("w_addr", 64'(w_addr), 64'(m_dec.waddr));
        check_output("we", 64'(we), 64'(m_dec.we));
        check_output("illegal", 64'(illegal), 64'(m_dec.illegal));
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("rst_valid", 64'(out_valid), 64'd0);
        check_output("rst_reg1", 64'(reg1), 64'd0);
        check_output("rst_aluop", 64'(aluop), 64'd0);
        rst = 1'b0;
        apply_stimulus();

        // ORI $1,$0,0x1234
        in_valid = 1'b1; pc = 32'h100; inst = {6'h0d, 5'd0, 5'd1, 16'h1234};
        apply_stimulus();
        check_output("ori_valid", 64'(out_valid), 64'd1);
        check_output("ori_reg1", 64'(reg1), 64'd0);
        check_output("ori_reg2", 64'(reg2), 64'h1234);
        check_output("ori_waddr", 64'(w_addr), 64'd1);
        check_output("ori_we", 64'(we), 64'd1);

        // OR $3,$1,$2 with both stages writing $1: youngest wins
        pc = 32'h104; inst = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25};
        rs_data = 32'h11; rt_data = 32'h22;
        fwd_we = 2'b11; fwd_addr = {5'd1, 5'd1}; fwd_data = {32'd7, 32'd5};
        apply_stimulus();
        check_output("fwd_young", 64'(reg1), 64'd5);

        // OR $3,$0,$2 while stage 1 writes $0
        pc = 32'h108; inst = {6'h00, 5'd0, 5'd2, 5'd3, 5'd0, 6'h25}; rs_data = 32'hDEAD;
        fwd_we = 2'b10; fwd_addr = {5'd0, 5'd0}; fwd_data = {32'd9, 32'd0};
        apply_stimulus();
        check_output("fwd_zero", 64'(reg1), 64'd0);

        // Load-use: load to $4 in EX, ORI $5,$4,1 must stall one cycle
        pc = 32'h10c; inst = {6'h0d, 5'd4, 5'd5, 16'h0001}; rs_data = 32'h1111;
        ex_load = 1'b1; fwd_we = 2'b01; fwd_addr = {5'd0, 5'd4}; fwd_data = {32'd0, 32'h55};
        apply_stimulus();
        check_output("lu_ready", 64'(in_ready), 64'd0);
        check_output("lu_bubble", 64'(out_valid), 64'd0);
        ex_load = 1'b0; fwd_we = 2'b10; fwd_addr = {5'd4, 5'd0}; fwd_data = {32'hAB, 32'd0};
        apply_stimulus();
        check_output("lu_valid", 64'(out_valid), 64'd1);
        check_output("lu_reg1", 64'(reg1), 64'hAB);
        fwd_we = 2'b00;

        // Back-pressure: ANDI issues, then EX stalls for three cycles
        pc = 32'h110; inst = {6'h0c, 5'd1, 5'd2, 16'h00F0};
        apply_stimulus();
        pc = 32'h114; inst = {6'h0e, 5'd0, 5'd7, 16'h0005}; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apply_stimulus();
            check_output("bp_ready", 64'(in_ready), 64'd0);
            check_output("bp_reg2", 64'(reg2), 64'h00F0);
            check_output("bp_pc", 64'(out_pc), 64'h110);
        end
        out_ready = 1'b1;
        apply_stimulus();
        check_output("bp_next_waddr", 64'(w_addr), 64'd7);
        check_output("bp_next_reg2", 64'(reg2), 64'd5);

        // Flush with a held instruction and a new input: both lost
        flush = 1'b1; out_ready = 1'b0; pc = 32'h118; inst = {6'h0d, 5'd0, 5'd9, 16'h0042};
        apply_stimulus();
        check_output("flush_valid", 64'(out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        apply_stimulus();
        check_output("flush_after", 64'(out_valid), 64'd0);

        // Illegal word, NOP word and SRA $5,$6,3
        in_valid = 1'b1; pc = 32'h11c; inst = 32'hFC000000;
        apply_stimulus();
        check_output("ill_flag", 64'(illegal), 64'd1);
        check_output("ill_we", 64'(we), 64'd0);
        pc = 32'h120; inst = 32'd0;
        apply_stimulus();
        check_output("nop_valid", 64'(out_valid), 64'd1);
        check_output("nop_ill", 64'(illegal), 64'd0);
        pc = 32'h124; inst = {6'h00, 5'd0, 5'd6, 5'd5, 5'd3, 6'h03}; rt_data = 32'h800000F0;
        apply_stimulus();
        check_output("sra_reg1", 64'(reg1), 64'd3);
        check_output("sra_reg2", 64'(reg2), 64'h800000F0);
        check_output("sra_waddr", 64'(w_addr), 64'd5);

        // Random traffic, including occasional mid-stream resets and flushes
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            pc        = $urandom;
            inst      = rand_inst();
            rs_data   = $urandom;
            rt_data   = $urandom;
            fwd_we    = 2'($urandom_range(0, 3));
            fwd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_data  = {32'($urandom), 32'($urandom)};
            ex_load   = ($urandom_range(0, 2) == 0);
            apply_stimulus();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
